push_pop_sequencer: RTL
=======================

// Module: push_pop_sequencer
// PURPOSE
// Multi-register PUSH/POP engine for the Thumb core. Sits between decode/execute and the register file.
// Drives reads of register_file-style ports (PUSH) or writes to them (POP), the data-memory port, and the final SP update.
// Holds the pipeline via busy_o while a register list is sequenced.
// PARAMETERS
// DATA_W      32  register/memory data width
// ADDR_W      32  memory address width
// WORD_BYTES  4   address stride per register; stack is full-descending
// PORTS
// clk               in   1       core clock; all state on posedge
// rst_n             in   1       asynchronous reset, active-low
// start_i           in   1       one-cycle request; sampled only in IDLE
// is_pop_i          in   1       1=POP, 0=PUSH
// reg_list_i        in   9       bits[7:0]=r7..r0; bit8=LR (PUSH) / PC (POP)
// sp_i              in   ADDR_W  current SP, valid with start_i
// rf_rd_select_o    out  4       register read select (0-7, 4'he=LR)
// rf_rd_data_i      in   DATA_W  registered read data, valid 1 cycle after select
// rf_write_en_o     out  1       register write strobe (POP)
// rf_wr_select_o    out  4       register write select
// rf_data_o         out  DATA_W  register write data
// rf_sp_write_en_o  out  1       SP write strobe
// rf_sp_o           out  ADDR_W  new SP value
// pc_write_en_o     out  1       PC load strobe (POP with bit8)
// pc_o              out  DATA_W  PC load value
// mem_req_o         out  1       memory request, held until mem_ready_i
// mem_we_o          out  1       1=store
// mem_addr_o        out  ADDR_W  word address
// mem_wdata_o       out  DATA_W  store data (=rf_rd_data_i)
// mem_ready_i       in   1       request completes this cycle; ignored when mem_req_o=0
// mem_rdata_i       in   DATA_W  load data, valid with mem_ready_i
// busy_o            out  1       state != IDLE; drives pipeline stall
// done_o            out  1       one-cycle completion pulse
// BEHAVIOUR
// - Reset: state=IDLE; every output 0; internal list/addr/count cleared. Reset mid-op aborts with no SP write.
// - Service order: lowest set bit first, bit8 last. Addresses ascend by WORD_BYTES.
// - Count: n = popcount(reg_list_i), 0..9. base = sp_i - WORD_BYTES*n (PUSH) or sp_i (POP), mod 2^ADDR_W.
// - IDLE:     start_i with n>0: latch list/base/op; go to PUSH_RD or POP_MEM.
//             start_i with n=0: go to DONE (no access, no SP write).
//             start_i outside IDLE: ignored.
// - PUSH_RD:  rf_rd_select_o = index (bit8 -> 4'he) -> PUSH_MEM.
// - PUSH_MEM: hold select; mem_req_o=1, mem_we_o=1, mem_addr_o=addr.
//             On mem_ready_i: clear bit, addr += WORD_BYTES; next = more bits ? PUSH_RD : SP_UPD.
// - POP_MEM:  mem_req_o=1, mem_we_o=0. On mem_ready_i: capture rdata -> POP_WB.
// - POP_WB:   1 cycle. rf_write_en_o=1 with rf_wr_select_o=index and rf_data_o=captured data,
//             or for bit8: pc_write_en_o=1 and pc_o=data. Clear bit, addr += WORD_BYTES;
//             next = more bits ? POP_MEM : SP_UPD.
// - SP_UPD:   rf_sp_write_en_o=1; rf_sp_o = base (PUSH) or base + WORD_BYTES*n (POP) -> DONE.
// - DONE:     done_o=1 -> IDLE.
// - Strobes are 1 cycle. Outputs are registered, except mem_wdata_o (tracks rf_rd_data_i).
// - Latency, zero-wait memory: done_o lands 2n+2 cycles after start_i. Each memory wait cycle adds 1.
// - Integration: register-file stall must be low at the edge that ends PUSH_RD.
// STRUCTURE
// - cpu_pkg:
//     typedef enum pps_state_t {IDLE, PUSH_RD, PUSH_MEM, POP_MEM, POP_WB, SP_UPD, DONE};
//     REG_SP=4'hd, REG_LR=4'he, REG_PC=4'hf.
// - Sub-module reg_list_scan (combinational):
//     9-bit list -> lowest-set index, any_left flag, popcount.
// TESTING
// 1. PUSH {r0,r2,LR}, sp=0x2000:
//    stores 0x1FF4<-r0, 0x1FF8<-r2, 0x1FFC<-lr; rf_sp_o=0x1FF4; done_o at cycle 8.
// 2. POP {r1,PC}, sp=0x1FF0, mem returns 0xA, 0xB:
//    r1=0xA; pc_write_en_o with pc_o=0xB; rf_sp_o=0x1FF8; done_o at cycle 6.
// 3. reg_list=0:
//    done_o 1 cycle after start; no mem_req_o, no SP write.
// 4. PUSH {r7} with mem_ready_i delayed 3 cycles:
//    addr/we/select stable throughout; done_o at cycle 7.
// 5. rst_n low during the 2nd PUSH_MEM:
//    outputs 0 immediately; no SP write; next start runs normally.
// 6. start_i pulsed while busy:
//    ignored; exactly one done_o pulse.

Source files
------------

// File: rtl/push_pop_sequencer_pkg.sv
// Shared types, widths and helpers for the Thumb PUSH/POP register-list sequencer.
package push_pop_sequencer_pkg;

  localparam int PPS_DATA_W     = 32;
  localparam int PPS_ADDR_W     = 32;
  localparam int PPS_WORD_BYTES = 4;
  localparam int LIST_W         = 9;

  localparam logic [3:0] LIST_TOP = 4'd8;
  localparam logic [3:0] REG_LR   = 4'he;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_RD  = 3'd1,
    PUSH_MEM = 3'd2,
    POP_MEM  = 3'd3,
    POP_WB   = 3'd4,
    SP_UPD   = 3'd5,
    DONE     = 3'd6
  } pps_state_t;

  // List bit 8 is LR on the PUSH side; bits 0..7 map straight to r0..r7.
  function automatic logic [3:0] rd_select_of(input logic [3:0] bit_idx);
    logic [3:0] sel;
    if (bit_idx == LIST_TOP) begin
      sel = REG_LR;
    end else begin
      sel = bit_idx;
    end
    return sel;
  endfunction

endpackage

// File: rtl/push_pop_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the core/register file/memory (slave).
interface push_pop_sequencer_if
  import push_pop_sequencer_pkg::*;
#(
  parameter int DATA_W = PPS_DATA_W,
  parameter int ADDR_W = PPS_ADDR_W
) ();

  logic              start_i;
  logic              is_pop_i;
  logic [LIST_W-1:0] reg_list_i;
  logic [ADDR_W-1:0] sp_i;
  logic [3:0]        rf_rd_select_o;
  logic [DATA_W-1:0] rf_rd_data_i;
  logic              rf_write_en_o;
  logic [3:0]        rf_wr_select_o;
  logic [DATA_W-1:0] rf_data_o;
  logic              rf_sp_write_en_o;
  logic [ADDR_W-1:0] rf_sp_o;
  logic              pc_write_en_o;
  logic [DATA_W-1:0] pc_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              busy_o;
  logic              done_o;

  modport master (
    input  start_i, is_pop_i, reg_list_i, sp_i, rf_rd_data_i, mem_ready_i, mem_rdata_i,
    output rf_rd_select_o, rf_write_en_o, rf_wr_select_o, rf_data_o, rf_sp_write_en_o,
           rf_sp_o, pc_write_en_o, pc_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           busy_o, done_o
  );

  modport slave (
    output start_i, is_pop_i, reg_list_i, sp_i, rf_rd_data_i, mem_ready_i, mem_rdata_i,
    input  rf_rd_select_o, rf_write_en_o, rf_wr_select_o, rf_data_o, rf_sp_write_en_o,
           rf_sp_o, pc_write_en_o, pc_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
           busy_o, done_o
  );

endinterface

// File: rtl/push_pop_sequencer_reg_list_scan.sv
// Combinational scan of a 9-bit register list: lowest set index, any-left flag, popcount.
module push_pop_sequencer_reg_list_scan
  import push_pop_sequencer_pkg::*;
(
  input  logic [LIST_W-1:0] i_list,
  output logic [3:0]        o_low_idx,
  output logic              o_any,
  output logic [3:0]        o_count
);

  // Walk from the top bit down so the last hit is the lowest set bit.
  always_comb begin
    o_low_idx = 4'd0;
    o_count   = 4'd0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (i_list[i]) begin
        o_low_idx = 4'(i);
        o_count   = o_count + 4'd1;
      end else begin
        o_count   = o_count;
      end
    end
    o_any = (i_list != {LIST_W{1'b0}});
  end

endmodule

// File: rtl/push_pop_sequencer.sv
// PUSH/POP multi-register sequencer: walks a register list, drives register file, memory and SP update.
module push_pop_sequencer
  import push_pop_sequencer_pkg::*;
#(
  parameter int DATA_W     = PPS_DATA_W,
  parameter int ADDR_W     = PPS_ADDR_W,
  parameter int WORD_BYTES = PPS_WORD_BYTES
) (
  input logic                  clk,
  input logic                  rst_n,
  push_pop_sequencer_if.master bus
);

  pps_state_t        r_state, w_state_nx;
  logic [LIST_W-1:0] r_list, w_list_nx, w_list_rest, w_scan_in;
  logic [3:0]        r_cur, w_cur_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx, r_sp_new, w_sp_new_nx;
  logic [ADDR_W-1:0] w_span, w_stride;
  logic [3:0]        w_scan_idx, w_scan_cnt;
  logic              w_scan_any;

  logic [3:0]        r_rd_sel, w_rd_sel_nx, r_wr_sel, w_wr_sel_nx;
  logic              r_wr_en, w_wr_en_nx, r_sp_we, w_sp_we_nx, r_pc_we, w_pc_we_nx;
  logic              r_mem_req, w_mem_req_nx, r_mem_we, w_mem_we_nx;
  logic              r_busy, w_busy_nx, r_done, w_done_nx;
  logic [DATA_W-1:0] r_rf_data, w_rf_data_nx, r_pc, w_pc_nx;
  logic [ADDR_W-1:0] r_sp, w_sp_nx, r_mem_addr, w_mem_addr_nx;

  // In IDLE the scanner sizes the incoming list; afterwards it looks at the list minus the current bit.
  assign w_list_rest = r_list & (r_list - 9'd1);
  assign w_scan_in   = (r_state == IDLE) ? bus.reg_list_i : w_list_rest;
  assign w_stride    = ADDR_W'(WORD_BYTES);
  assign w_span      = w_stride * ADDR_W'(w_scan_cnt);

  push_pop_sequencer_reg_list_scan u_scan (
    .i_list    (w_scan_in),
    .o_low_idx (w_scan_idx),
    .o_any     (w_scan_any),
    .o_count   (w_scan_cnt)
  );

  // Next-state and working-register update.
  always_comb begin
    w_state_nx  = r_state;
    w_list_nx   = r_list;
    w_cur_nx    = r_cur;
    w_addr_nx   = r_addr;
    w_sp_new_nx = r_sp_new;
    case (r_state)
      IDLE: begin
        if (bus.start_i && (w_scan_cnt == 4'd0)) begin
          w_state_nx = DONE;
        end else if (bus.start_i) begin
          w_list_nx = bus.reg_list_i;
          w_cur_nx  = w_scan_idx;
          if (bus.is_pop_i) begin
            w_state_nx  = POP_MEM;
            w_addr_nx   = bus.sp_i;
            w_sp_new_nx = bus.sp_i + w_span;
          end else begin
            w_state_nx  = PUSH_RD;
            w_addr_nx   = bus.sp_i - w_span;
            w_sp_new_nx = bus.sp_i - w_span;
          end
        end else begin
          w_state_nx = IDLE;
        end
      end
      PUSH_RD: w_state_nx = PUSH_MEM;
      PUSH_MEM: begin
        if (bus.mem_ready_i) begin
          w_list_nx  = w_list_rest;
          w_cur_nx   = w_scan_idx;
          w_addr_nx  = r_addr + w_stride;
          w_state_nx = w_scan_any ? PUSH_RD : SP_UPD;
        end else begin
          w_state_nx = PUSH_MEM;
        end
      end
      POP_MEM: w_state_nx = bus.mem_ready_i ? POP_WB : POP_MEM;
      POP_WB: begin
        w_list_nx  = w_list_rest;
        w_cur_nx   = w_scan_idx;
        w_addr_nx  = r_addr + w_stride;
        w_state_nx = w_scan_any ? POP_MEM : SP_UPD;
      end
      SP_UPD:  w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Output values for the state being entered, so every output comes straight from a flop.
  always_comb begin
    w_rd_sel_nx   = 4'd0;
    w_wr_en_nx    = 1'b0;
    w_wr_sel_nx   = 4'd0;
    w_rf_data_nx  = {DATA_W{1'b0}};
    w_sp_we_nx    = 1'b0;
    w_sp_nx       = {ADDR_W{1'b0}};
    w_pc_we_nx    = 1'b0;
    w_pc_nx       = {DATA_W{1'b0}};
    w_mem_req_nx  = 1'b0;
    w_mem_we_nx   = 1'b0;
    w_mem_addr_nx = {ADDR_W{1'b0}};
    w_done_nx     = 1'b0;
    case (w_state_nx)
      PUSH_RD: w_rd_sel_nx = rd_select_of(w_cur_nx);
      PUSH_MEM: begin
        w_rd_sel_nx   = rd_select_of(w_cur_nx);
        w_mem_req_nx  = 1'b1;
        w_mem_we_nx   = 1'b1;
        w_mem_addr_nx = w_addr_nx;
      end
      POP_MEM: begin
        w_mem_req_nx  = 1'b1;
        w_mem_addr_nx = w_addr_nx;
      end
      // POP_WB is only entered on the edge that completes the load, so mem_rdata_i is valid here.
      POP_WB: begin
        if (w_cur_nx == LIST_TOP) begin
          w_pc_we_nx = 1'b1;
          w_pc_nx    = bus.mem_rdata_i;
        end else begin
          w_wr_en_nx   = 1'b1;
          w_wr_sel_nx  = w_cur_nx;
          w_rf_data_nx = bus.mem_rdata_i;
        end
      end
      SP_UPD: begin
        w_sp_we_nx = 1'b1;
        w_sp_nx    = w_sp_new_nx;
      end
      DONE:    w_done_nx = 1'b1;
      default: w_done_nx = 1'b0;
    endcase
    w_busy_nx = (w_state_nx != IDLE);
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_list     <= {LIST_W{1'b0}};
      r_cur      <= 4'd0;
      r_addr     <= {ADDR_W{1'b0}};
      r_sp_new   <= {ADDR_W{1'b0}};
      r_rd_sel   <= 4'd0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= 4'd0;
      r_rf_data  <= {DATA_W{1'b0}};
      r_sp_we    <= 1'b0;
      r_sp       <= {ADDR_W{1'b0}};
      r_pc_we    <= 1'b0;
      r_pc       <= {DATA_W{1'b0}};
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= {ADDR_W{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_list     <= w_list_nx;
      r_cur      <= w_cur_nx;
      r_addr     <= w_addr_nx;
      r_sp_new   <= w_sp_new_nx;
      r_rd_sel   <= w_rd_sel_nx;
      r_wr_en    <= w_wr_en_nx;
      r_wr_sel   <= w_wr_sel_nx;
      r_rf_data  <= w_rf_data_nx;
      r_sp_we    <= w_sp_we_nx;
      r_sp       <= w_sp_nx;
      r_pc_we    <= w_pc_we_nx;
      r_pc       <= w_pc_nx;
      r_mem_req  <= w_mem_req_nx;
      r_mem_we   <= w_mem_we_nx;
      r_mem_addr <= w_mem_addr_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
    end
  end

  assign bus.rf_rd_select_o   = r_rd_sel;
  assign bus.rf_write_en_o    = r_wr_en;
  assign bus.rf_wr_select_o   = r_wr_sel;
  assign bus.rf_data_o        = r_rf_data;
  assign bus.rf_sp_write_en_o = r_sp_we;
  assign bus.rf_sp_o          = r_sp;
  assign bus.pc_write_en_o    = r_pc_we;
  assign bus.pc_o             = r_pc;
  assign bus.mem_req_o        = r_mem_req;
  assign bus.mem_we_o         = r_mem_we;
  assign bus.mem_addr_o       = r_mem_addr;
  assign bus.mem_wdata_o      = bus.rf_rd_data_i;
  assign bus.busy_o           = r_busy;
  assign bus.done_o           = r_done;

endmodule
